// File: rtl/tlul_rsp_err_monitor.sv
// rtl/tlul_rsp_err_monitor.sv - host-side TL-UL response error monitor with sticky record and alert handshake

package tlul_pkg;
   parameter int TL_AIW = 8;

   typedef struct packed {
      logic              a_valid;
      logic [2:0]        a_opcode;
      logic [TL_AIW-1:0] a_source;
      logic [31:0]       a_address;
      logic [3:0]        a_mask;
      logic [31:0]       a_data;
      logic              d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic              d_valid;
      logic [2:0]        d_opcode;
      logic [TL_AIW-1:0] d_source;
      logic [31:0]       d_data;
      logic              d_error;
      logic              a_ready;
   } tl_d2h_t;
endpackage

module tlul_rsp_err_monitor
   import tlul_pkg::*;
#(
   parameter int MaxOutstanding = 8,
   parameter int CntW           = 8,
   localparam int OutW          = $clog2(MaxOutstanding + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  tl_h2d_t           tl_h2d_i,
   input  tl_d2h_t           tl_d2h_i,
   input  logic              intg_err_i,
   input  logic              clr_i,
   input  logic              alert_ack_i,
   output logic [OutW-1:0]   outstanding_o,
   output logic [CntW-1:0]   err_cnt_o,
   output logic              err_valid_o,
   output logic [1:0]        err_type_o,
   output logic [TL_AIW-1:0] err_source_o,
   output logic              alert_req_o
);

   localparam logic [OutW-1:0] OutMax = OutW'(MaxOutstanding);

   localparam logic [1:0] ErrIntg  = 2'b01;
   localparam logic [1:0] ErrUnexp = 2'b10;
   localparam logic [1:0] ErrOvf   = 2'b11;

   typedef enum logic [1:0] {
      ALERT_IDLE    = 2'd0,
      ALERT_REQ     = 2'd1,
      ALERT_ACKWAIT = 2'd2
   } alert_state_e;

   alert_state_e alert_state;
   logic         pend;

   logic              a_hs;
   logic              d_hs;
   logic              ev;
   logic [1:0]        ev_type;
   logic [TL_AIW-1:0] ev_source;

   // Channels are only observed; payload fields other than the IDs are not needed here.
   logic unused_tl;
   assign unused_tl = ^{tl_h2d_i.a_opcode, tl_h2d_i.a_address, tl_h2d_i.a_mask, tl_h2d_i.a_data,
                        tl_d2h_i.d_opcode, tl_d2h_i.d_data, tl_d2h_i.d_error};

   assign a_hs = tl_h2d_i.a_valid & tl_d2h_i.a_ready;
   assign d_hs = tl_d2h_i.d_valid & tl_h2d_i.d_ready;

   // Classify at most one error event per cycle: integrity beats unexpected beats overflow.
   always_comb begin
      ev        = 1'b0;
      ev_type   = 2'b00;
      ev_source = '0;
      if (d_hs && intg_err_i) begin
         ev        = 1'b1;
         ev_type   = ErrIntg;
         ev_source = tl_d2h_i.d_source;
      end else if (d_hs && !a_hs && (outstanding_o == '0)) begin
         ev        = 1'b1;
         ev_type   = ErrUnexp;
         ev_source = tl_d2h_i.d_source;
      end else if (a_hs && !d_hs && (outstanding_o == OutMax)) begin
         ev        = 1'b1;
         ev_type   = ErrOvf;
         ev_source = tl_h2d_i.a_source;
      end
   end

   // In-flight tracking; pins at 0 and at the maximum instead of wrapping.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         outstanding_o <= '0;
      end else if (a_hs && !d_hs && (outstanding_o != OutMax)) begin
         outstanding_o <= outstanding_o + OutW'(1);
      end else if (d_hs && !a_hs && (outstanding_o != '0)) begin
         outstanding_o <= outstanding_o - OutW'(1);
      end
   end

   // Sticky first-error record and saturating counter; an event in the clear cycle starts a fresh record.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_valid_o  <= 1'b0;
         err_type_o   <= 2'b00;
         err_source_o <= '0;
         err_cnt_o    <= '0;
      end else if (ev) begin
         if (clr_i || !err_valid_o) begin
            err_valid_o  <= 1'b1;
            err_type_o   <= ev_type;
            err_source_o <= ev_source;
         end
         if (clr_i) begin
            err_cnt_o <= CntW'(1);
         end else if (err_cnt_o != '1) begin
            err_cnt_o <= err_cnt_o + CntW'(1);
         end
      end else if (clr_i) begin
         err_valid_o  <= 1'b0;
         err_type_o   <= 2'b00;
         err_source_o <= '0;
         err_cnt_o    <= '0;
      end
   end

   // Four-phase alert handshake; events during REQ merge, events during ACKWAIT are remembered in pend.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         alert_state <= ALERT_IDLE;
         alert_req_o <= 1'b0;
         pend        <= 1'b0;
      end else begin
         case (alert_state)
            ALERT_IDLE: begin
               if (ev) begin
                  alert_state <= ALERT_REQ;
                  alert_req_o <= 1'b1;
                  pend        <= 1'b0;
               end
            end
            ALERT_REQ: begin
               if (alert_ack_i) begin
                  alert_state <= ALERT_ACKWAIT;
                  alert_req_o <= 1'b0;
               end
            end
            ALERT_ACKWAIT: begin
               if (!alert_ack_i) begin
                  if (pend || ev) begin
                     alert_state <= ALERT_REQ;
                     alert_req_o <= 1'b1;
                     pend        <= 1'b0;
                  end else begin
                     alert_state <= ALERT_IDLE;
                     alert_req_o <= 1'b0;
                  end
               end else if (ev) begin
                  pend <= 1'b1;
               end
            end
            default: begin
               alert_state <= ALERT_IDLE;
               alert_req_o <= 1'b0;
               pend        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/tlul_rsp_err_monitor.md
# tlul_rsp_err_monitor

Host-side TL-UL response error monitor placed directly downstream of the response integrity checker. It observes the A and D channels at the host port and consumes the checker's error output. It tracks outstanding transactions, classifies response errors, and keeps a saturating error count plus a sticky first-error record. Each new error episode is signalled to the host error/alert logic over a four-phase req/ack handshake.

## Interface
- MaxOutstanding, default 8: maximum in-flight A-channel requests tracked; ≥1.
- CntW, default 8: error counter width; ≥1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- tl_h2d_i  in  tl_h2d_t  host A channel (observed only).
- tl_d2h_i  in  tl_d2h_t  device D channel (observed only).
- intg_err_i  in  1  response integrity error from the checker; already gated by d_valid.
- clr_i  in  1  clears the error record and the counter.
- alert_ack_i  in  1  alert handshake acknowledge.
- outstanding_o  out  $clog2(MaxOutstanding+1)  current in-flight count.
- err_cnt_o  out  CntW  saturating error-event count.
- err_valid_o  out  1  sticky: first-error record is valid.
- err_type_o  out  2  first error type: 01 integrity, 10 unexpected response, 11 overflow.
- err_source_o  out  TL_AIW  source ID of the first error.
- alert_req_o  out  1  alert request (four-phase).

## Operation
- Handshakes: a_hs = a_valid & a_ready; d_hs = d_valid & d_ready. All evaluation uses handshakes only.
- Outstanding count update:
  - a_hs only: +1.
  - d_hs only: −1.
  - Both in the same cycle: unchanged.
  - d_hs only at 0: stays 0 (unexpected response).
  - a_hs only at MaxOutstanding: stays at max (overflow).
- Error classification, at most one event per cycle, priority in this order:
  - Integrity: d_hs & intg_err_i.
  - Unexpected: d_hs & outstanding==0 & no a_hs.
  - Overflow: a_hs & outstanding==MaxOutstanding & no d_hs.
- Event source ID:
  - Integrity and unexpected: d_source.
  - Overflow: a_source.
- First-error record: err_type_o and err_source_o load only when err_valid_o==0; err_valid_o is then set and held.
- Counter: err_cnt_o increments by 1 per event and saturates at 2^CntW−1.
- clr_i:
  - Zeroes err_valid_o, err_type_o, err_source_o and err_cnt_o.
  - Does not touch outstanding_o or the alert FSM.
  - clr_i together with an event: the event wins; the record loads and err_cnt_o=1.
- Alert FSM, states IDLE, REQ, ACKWAIT:
  - IDLE: event → REQ.
  - REQ (alert_req_o=1): alert_ack_i=1 → ACKWAIT. Events while in REQ are merged.
  - ACKWAIT (alert_req_o=0): events set a pend flag. alert_ack_i=0 → REQ if pend or an event this cycle, else IDLE. pend clears on entering REQ.

## Timing
- Reset values: all outputs 0, FSM in IDLE, pend=0.
- All outputs are registered.
- Latency from a handshake edge to the outputs:
  - outstanding_o, err_*: updated 1 cycle after the handshake edge.
  - alert_req_o: rises 1 cycle after the event.
- alert_req_o falls 1 cycle after alert_ack_i is sampled high.
- Minimum low time between alert requests: 1 cycle after ack deasserts.
- Reset mid-handshake: everything returns to reset values. A held alert_ack_i=1 after reset has no effect in IDLE.
- No combinational path from any input to any output.

## Test plan
- Reset, then 3 a_hs followed by 3 d_hs, no errors → outstanding_o 1,2,3,2,1,0; err_cnt_o=0; alert_req_o stays 0.
- a_hs source 0x05, then d_hs source 0x05 with intg_err_i=1 → next cycle err_valid_o=1, err_type_o=01, err_source_o=0x05, err_cnt_o=1, alert_req_o=1; ack high → req low; ack low → IDLE.
- d_hs at outstanding 0 with d_source 0x12, then integrity error on a later response → err_type_o=10, err_source_o=0x12 (record keeps the first error), err_cnt_o=2, one alert only (merged in REQ).
- MaxOutstanding=8: 9 a_hs with no responses → outstanding_o saturates at 8; err_type_o=11 with the 9th a_source; simultaneous a_hs+d_hs at 8 → no overflow.
- CntW=2: 5 integrity errors → err_cnt_o saturates at 3; clr_i in the same cycle as a 6th error → err_cnt_o=1, err_valid_o=1.
- Error while in ACKWAIT, ack still high → no req; when ack drops, alert_req_o rises again the next cycle.
